// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of a combinational ALU: takes one op at a time, holds the operands
// steady for SETTLE cycles, captures the ALU result and presents it downstream.
module alu_issue_ctrl #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_cin,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic             alu_cin,
    output logic [79:0]      alu_oper,
    input  logic [7:0]       alu_sum,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);
    localparam int S_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int SC_W  = (S_EFF > 1) ? $clog2(S_EFF) : 1;
    localparam logic [SC_W-1:0] SC_INIT = SC_W'(S_EFF - 1);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_a, r_b, r_sum;
    logic              r_cin, r_cout, r_err;
    logic [2:0]        r_op;
    logic [SC_W-1:0]   r_cnt;
    logic [CNT_W-1:0]  r_count;
    logic              w_accept, w_capture, w_ack, w_hold;

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_ack     = 1'b0;
        unique case (r_state)
            IDLE: if (in_valid) begin
                w_accept = 1'b1;
                w_next   = in_op[3] ? DONE : HOLD;
            end
            HOLD: if (r_cnt == '0) begin
                w_capture = 1'b1;
                w_next    = DONE;
            end
            DONE: if (out_ready) begin
                w_ack  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_hold    = (r_state == HOLD);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    // ALU inputs are only driven while an op is settling; zero otherwise.
    assign alu_a     = w_hold ? r_a : 8'h00;
    assign alu_b     = w_hold ? r_b : 8'h00;
    assign alu_cin   = w_hold & r_cin;

    always_comb begin
        alu_oper = '0;
        if (w_hold) begin
            unique case (r_op)
                3'd0: alu_oper = 80'("and");
                3'd1: alu_oper = 80'("subtract");
                3'd2: alu_oper = 80'("subtract_a");
                3'd3: alu_oper = 80'("or_ab");
                3'd4: alu_oper = 80'("and_ab");
                3'd5: alu_oper = 80'("not_ab");
                3'd6: alu_oper = 80'("exor");
                default: alu_oper = 80'("exnor");
            endcase
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;
    assign out_err  = r_err;
    assign out_zero = (r_sum == 8'h00);
    assign op_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= in_a;
                r_b   <= in_b;
                r_cin <= in_cin;
                r_op  <= in_op[2:0];
                r_cnt <= SC_INIT;
                // Illegal ops skip the ALU entirely and report a zeroed result.
                if (in_op[3]) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_err  <= 1'b1;
                end
            end
            if (w_hold && r_cnt != '0) r_cnt <= r_cnt - SC_W'(1);
            if (w_capture) begin
                r_sum  <= alu_sum;
                r_cout <= alu_cout;
                r_err  <= 1'b0;
            end
            if (w_ack) r_count <= r_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a string-decoding ALU model feeds the DUT, and results are
// checked against an opcode-level reference model.
module tb_alu_issue_ctrl;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = '0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, alu_cin, alu_cout, out_valid, out_cout, out_zero, out_err;
    logic [7:0]  alu_a, alu_b, alu_sum, out_sum;
    logic [79:0] alu_oper;
    logic [15:0] op_count;

    logic        in_ready2, alu_cin2, alu_cout2, out_valid2, out_cout2, out_zero2, out_err2;
    logic [7:0]  alu_a2, alu_b2, alu_sum2, out_sum2;
    logic [79:0] alu_oper2;
    logic [1:0]  op_count2;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [79:0] exp_str(input logic [3:0] op);
        case (op)
            4'd0: return 80'("and");
            4'd1: return 80'("subtract");
            4'd2: return 80'("subtract_a");
            4'd3: return 80'("or_ab");
            4'd4: return 80'("and_ab");
            4'd5: return 80'("not_ab");
            4'd6: return 80'("exor");
            4'd7: return 80'("exnor");
            default: return 80'd0;
        endcase
    endfunction

    // Stand-in for the real ALU: decodes the operation string.
    function automatic logic [8:0] alu_model(input logic [79:0] s, input logic [7:0] a, b,
                                             input logic c);
        if (s == 80'("and"))        return {1'b0, a & b};
        if (s == 80'("subtract"))   return {1'b0, a} + {1'b0, ~b} + {8'd0, c};
        if (s == 80'("subtract_a")) return {1'b0, b} + {1'b0, ~a} + {8'd0, c};
        if (s == 80'("or_ab"))      return {1'b0, a | b};
        if (s == 80'("and_ab"))     return {1'b0, ~(a & b)};
        if (s == 80'("not_ab"))     return {1'b0, ~(a | b)};
        if (s == 80'("exor"))       return {1'b0, a ^ b};
        if (s == 80'("exnor"))      return {1'b0, ~(a ^ b)};
        return 9'h1EE;
    endfunction

    assign {alu_cout, alu_sum}   = alu_model(alu_oper, alu_a, alu_b, alu_cin);
    assign {alu_cout2, alu_sum2} = alu_model(alu_oper2, alu_a2, alu_b2, alu_cin2);

    // Reference: {err, cout, sum} by opcode number, integer arithmetic.
    function automatic logic [9:0] ref_f(input logic [3:0] op, input logic [7:0] a, b,
                                         input logic c);
        int t;
        case (op)
            4'd0: return {2'b00, a & b};
            4'd1: begin t = int'(a) + (255 - int'(b)) + int'(c); return {1'b0, t > 255, t[7:0]}; end
            4'd2: begin t = int'(b) + (255 - int'(a)) + int'(c); return {1'b0, t > 255, t[7:0]}; end
            4'd3: return {2'b00, a | b};
            4'd4: return {2'b00, ~(a & b)};
            4'd5: return {2'b00, ~(a | b)};
            4'd6: return {2'b00, a ^ b};
            4'd7: return {2'b00, ~(a ^ b)};
            default: return {1'b1, 9'd0};
        endcase
    endfunction

    alu_issue_ctrl #(.SETTLE(SETTLE), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_oper(alu_oper), .alu_sum(alu_sum), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_zero(out_zero), .out_err(out_err), .op_count(op_count));

    alu_issue_ctrl #(.SETTLE(SETTLE), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_cin(alu_cin2), .alu_oper(alu_oper2), .alu_sum(alu_sum2), .alu_cout(alu_cout2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2), .out_cout(out_cout2),
        .out_zero(out_zero2), .out_err(out_err2), .op_count(op_count2));

    // Issues one op; lat = edges from accept to out_valid (-1 on timeout). holdok tracks
    // operand stability during HOLD and idle ALU inputs / low in_ready once DONE.
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, b, input logic c,
                         input logic rdy, output int lat, output int holdn, output logic holdok);
        int w;
        logic fin;
        lat = -1; holdn = 0; holdok = 1'b1; fin = 1'b0; w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (in_ready) begin
            in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = c; out_ready = rdy;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int i = 1; i < 50 && !fin; i++) begin
                if (out_valid) begin
                    lat = i; fin = 1'b1;
                    if (in_ready !== 1'b0 || alu_oper !== 80'd0 || alu_a !== 8'd0) holdok = 1'b0;
                end else begin
                    holdn++;
                    if (alu_a !== a || alu_b !== b || alu_cin !== c ||
                        alu_oper !== exp_str(op) || in_ready !== 1'b0) holdok = 1'b0;
                    @(posedge clk); #1;
                end
            end
            if (fin && rdy) begin
                @(posedge clk); #1;
                exp_cnt++;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_oper !== 80'd0 || alu_a !== 8'd0 ||
            alu_b !== 8'd0 || alu_cin !== 1'b0 || out_sum !== 8'd0 || out_cout !== 1'b0 ||
            out_err !== 1'b0 || op_count !== 16'd0) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b a=%h sum=%h err=%b cnt=%0d, need rdy=1 rest 0",
                     in_ready, out_valid, alu_a, out_sum, out_err, op_count);
        end
        @(negedge clk); rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_basic;
        int lat, hn; logic ok;
        do_op(4'd0, 8'h90, 8'h87, 1'b1, 1'b1, lat, hn, ok);
        total++;
        if (lat !== SETTLE + 1 || hn !== SETTLE || ok !== 1'b1) begin
            bad++;
            $display("FAIL basic_timing: lat=%0d hold=%0d ok=%b, need lat=%0d hold=%0d ok=1",
                     lat, hn, ok, SETTLE + 1, SETTLE);
        end
        total++;
        if (out_sum !== 8'h80 || out_zero !== 1'b0 || out_err !== 1'b0 || op_count !== 16'd1) begin
            bad++;
            $display("FAIL basic_result: sum=%h zero=%b err=%b cnt=%0d, need 80 0 0 1",
                     out_sum, out_zero, out_err, op_count);
        end
    endtask

    task automatic test_back_to_back;
        int lat, hn; logic ok;
        logic [7:0] s1;
        do_op(4'd3, 8'h90, 8'h87, 1'b1, 1'b1, lat, hn, ok);
        s1 = out_sum;
        total++;
        if (s1 !== 8'h97 || ok !== 1'b1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_or: sum=%h ok=%b rdy=%b, need 97 1 1", s1, ok, in_ready);
        end
        do_op(4'd6, 8'h90, 8'h87, 1'b1, 1'b1, lat, hn, ok);
        total++;
        if (out_sum !== 8'h17 || ok !== 1'b1 || lat !== SETTLE + 1 ||
            op_count !== 16'(exp_cnt) || op_count2 !== 2'(exp_cnt)) begin
            bad++;
            $display("FAIL b2b_xor: sum=%h ok=%b lat=%0d cnt=%0d/%0d, need 17 1 %0d %0d",
                     out_sum, ok, lat, op_count, op_count2, SETTLE + 1, exp_cnt);
        end
    endtask

    task automatic test_illegal;
        int lat, hn; logic ok;
        do_op(4'hA, 8'h55, 8'h33, 1'b1, 1'b1, lat, hn, ok);
        total++;
        if (lat !== 1 || hn !== 0 || ok !== 1'b1) begin
            bad++;
            $display("FAIL illegal_timing: lat=%0d hold=%0d ok=%b, need 1 0 1", lat, hn, ok);
        end
        total++;
        if (out_err !== 1'b1 || out_sum !== 8'd0 || out_cout !== 1'b0 || out_zero !== 1'b1 ||
            alu_oper !== 80'd0) begin
            bad++;
            $display("FAIL illegal_result: err=%b sum=%h cout=%b zero=%b, need 1 00 0 1",
                     out_err, out_sum, out_cout, out_zero);
        end
    endtask

    task automatic test_stall;
        int lat, hn; logic ok;
        logic [9:0] r;
        logic stable;
        r = ref_f(4'd1, 8'h20, 8'h30, 1'b1);
        do_op(4'd1, 8'h20, 8'h30, 1'b1, 1'b0, lat, hn, ok);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0]; in_op = 4'd0; in_a = 8'hFF; in_b = 8'hFF;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== r[7:0] ||
                out_cout !== r[8] || op_count !== 16'(exp_cnt)) stable = 1'b0;
        end
        in_valid = 1'b0;
        total++;
        if (stable !== 1'b1 || lat !== SETTLE + 1) begin
            bad++;
            $display("FAIL stall_hold: stable=%b lat=%0d sum=%h, need 1 %0d %h",
                     stable, lat, out_sum, SETTLE + 1, r[7:0]);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        exp_cnt++;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== r[7:0] ||
            op_count !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL stall_release: vld=%b rdy=%b sum=%h cnt=%0d, need 0 1 %h %0d",
                     out_valid, in_ready, out_sum, op_count, r[7:0], exp_cnt);
        end
    endtask

    task automatic test_reset_mid_hold;
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd7; in_a = 8'h0F; in_b = 8'h3C; in_cin = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b0; #1;
        exp_cnt = 0;
        total++;
        if (alu_oper !== 80'd0 || alu_a !== 8'd0 || alu_b !== 8'd0 || out_valid !== 1'b0 ||
            out_sum !== 8'd0 || out_err !== 1'b0 || op_count !== 16'd0 || op_count2 !== 2'd0) begin
            bad++;
            $display("FAIL rst_hold: oper=%h a=%h vld=%b sum=%h cnt=%0d, need all 0",
                     alu_oper, alu_a, out_valid, out_sum, op_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== 16'd0) begin
            bad++;
            $display("FAIL rst_release: rdy=%b vld=%b cnt=%0d, need 1 0 0",
                     in_ready, out_valid, op_count);
        end
    endtask

    task automatic test_wrap;
        int lat, hn; logic ok;
        logic [1:0] seq [5];
        logic [1:0] want;
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
        for (int i = 0; i < 5; i++) begin
            do_op(4'(i), 8'(i * 17), 8'h5A, 1'b0, 1'b1, lat, hn, ok);
            want = seq[i];
            total++;
            if (op_count2 !== want || op_count !== 16'(i + 1)) begin
                bad++;
                $display("FAIL wrap_%0d: cnt2=%0d cnt=%0d, need %0d %0d",
                         i, op_count2, op_count, want, i + 1);
            end
        end
    endtask

    task automatic test_random;
        int lat, hn; logic ok;
        logic [3:0] op; logic [7:0] a, b; logic c;
        logic [9:0] r;
        int want_lat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
            c = 1'($urandom);
            r = ref_f(op, a, b, c);
            want_lat = op[3] ? 1 : SETTLE + 1;
            do_op(op, a, b, c, 1'b1, lat, hn, ok);
            total++;
            if (lat !== want_lat || ok !== 1'b1 || out_sum !== r[7:0] || out_cout !== r[8] ||
                out_err !== r[9] || out_zero !== (r[7:0] == 8'd0) ||
                op_count !== 16'(exp_cnt) || op_count2 !== 2'(exp_cnt)) begin
                bad++;
                $display("FAIL rand_%0d op=%h a=%h b=%h c=%b: lat=%0d ok=%b err=%b cout=%b sum=%h cnt=%0d, need lat=%0d err=%b cout=%b sum=%h cnt=%0d",
                         i, op, a, b, c, lat, ok, out_err, out_cout, out_sum, op_count,
                         want_lat, r[9], r[8], r[7:0], exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_illegal;
        test_stall;
        test_reset_mid_hold;
        test_wrap;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
